vmem_arbiter: RTL

- Shares the single-port 12-bit x 327680-entry video RAM between two requesters: VGA scan-out (read) and a pixel writer (write).
- Scan-out has absolute priority and a fixed 1-cycle read latency.
- Writer pixels are buffered in a small FIFO and drained into RAM only in cycles where scan-out is idle (blanking).
- Sits between the VGA timing/colour path and the RAM instance, and drives every RAM control pin.

---
 rtl/vmem_pkg.sv | 21 ++
 rtl/vmem_wr_fifo.sv | 53 +++++
 rtl/vmem_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/vmem_pkg.sv
// Shared types and sizes for the video-RAM arbiter: 19-bit pixel addresses, 4:4:4 pixels,
// and the queued-write entry format.
package vmem_pkg;
    localparam int VMEM_ADDR_W = 19;
    localparam int VMEM_DATA_W = 12;
    localparam int VMEM_SIZE   = 327680;

    typedef logic [VMEM_ADDR_W-1:0] vaddr_t;
    typedef logic [VMEM_DATA_W-1:0] pixel_t;

    typedef struct packed {
        vaddr_t addr;
        pixel_t data;
    } wr_entry_t;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_DISP,
        GNT_DRAIN
    } grant_e;
endpackage

// File: rtl/vmem_wr_fifo.sv
// Small synchronous FIFO of pending pixel writes; head is visible combinationally.
// Push when full and pop when empty are ignored.
module vmem_wr_fifo
    import vmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  wr_entry_t              din,
    input  logic                   pop,
    output wr_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

    wr_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Contents need no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/vmem_arbiter.sv
// Single-port video RAM arbiter: scan-out reads win every cycle (1-cycle latency),
// buffered pixel writes drain only when scan-out is idle; wr_ready drops when the buffer is full.
module vmem_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 12,
    parameter int VMEM_SIZE    = 327680,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          disp_en,
    input  logic [ADDR_W-1:0]             disp_addr,
    output logic [DATA_W-1:0]             disp_data,
    output logic                          disp_valid,
    input  logic                          wr_valid,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic                          ram_en,
    output logic                          ram_wen,
    output logic [ADDR_W-1:0]             ram_read_addr,
    output logic [ADDR_W-1:0]             ram_write_addr,
    output logic [DATA_W-1:0]             ram_datain,
    input  logic [DATA_W-1:0]             ram_dataout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_oob,
    output logic                          starve,
    input  logic                          clr_err
);
    import vmem_pkg::*;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]     STARVE_L = CW'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] SIZE_L   = ADDR_W'(VMEM_SIZE);

    grant_e        grant;
    wr_entry_t     din;
    wr_entry_t     head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          xfer;
    logic          oob;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_cnt_nxt;

    always_comb begin
        grant = GNT_IDLE;
        if (!rst) begin
            if (disp_en)     grant = GNT_DISP;
            else if (!empty) grant = GNT_DRAIN;
        end
    end

    always_comb begin
        ram_en         = 1'b0;
        ram_wen        = 1'b0;
        ram_read_addr  = '0;
        ram_write_addr = '0;
        ram_datain     = '0;
        case (grant)
            GNT_DISP: begin
                ram_en        = 1'b1;
                ram_read_addr = disp_addr;
            end
            GNT_DRAIN: begin
                ram_en         = 1'b1;
                ram_wen        = 1'b1;
                ram_write_addr = ADDR_W'(head.addr);
                ram_datain     = DATA_W'(head.data);
            end
            default: ;
        endcase
    end

    assign wr_ready  = !full;
    assign xfer      = wr_valid && wr_ready;
    assign oob       = (wr_addr >= SIZE_L);
    assign push      = xfer && !oob && !rst;
    assign pop       = (grant == GNT_DRAIN);
    assign din.addr  = vaddr_t'(wr_addr);
    assign din.data  = pixel_t'(wr_data);

    vmem_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // The RAM's own output register supplies the 1-cycle latency; gate it so idle cycles read 0.
    assign disp_data = disp_valid ? ram_dataout : '0;

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (pop)
            starve_cnt_nxt = '0;
        else if (full && disp_en && starve_cnt != STARVE_L)
            starve_cnt_nxt = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_valid <= 1'b0;
            err_oob    <= 1'b0;
            starve     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            disp_valid <= (grant == GNT_DISP);
            starve_cnt <= starve_cnt_nxt;
            if (clr_err) begin
                err_oob <= 1'b0;
                starve  <= 1'b0;
            end else begin
                if (xfer && oob)                  err_oob <= 1'b1;
                if (starve_cnt_nxt == STARVE_L)   starve  <= 1'b1;
            end
        end
    end
endmodule
